// File: rtl/gf_inv_iter.sv
// Iterative GF(2^W) multiplicative inverter: computes a^(2^W-2) by W-1 rounds of
// square-and-multiply, with valid/ready handshakes, tag passthrough and a zero flag.
module gf_inv_iter #(
    parameter int         W     = 8,
    parameter logic [W:0] POLY  = 9'h11B,
    parameter int         TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_zero,
    output logic             busy
);

    localparam int              CW       = $clog2(W);
    localparam logic [CW-1:0]   CNT_LAST = CW'(W - 2);
    localparam logic [W-1:0]    RED      = POLY[W-1:0];

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_reg, state_next;
    logic [W-1:0]     sq_reg, sq_next;
    logic [W-1:0]     res_reg, res_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic             zf_reg, zf_next;
    logic [CW-1:0]    cnt_reg, cnt_next;

    // Multiply by x with reduction; shared by the squarer and the product network.
    function automatic logic [W-1:0] xtime(input logic [W-1:0] v);
        return {v[W-2:0], 1'b0} ^ (v[W-1] ? RED : '0);
    endfunction

    function automatic logic [W-1:0] gf_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] acc;
        logic [W-1:0] sh;
        acc = '0;
        sh  = x;
        for (int i = 0; i < W; i++) begin
            if (y[i])
                acc = acc ^ sh;
            sh = xtime(sh);
        end
        return acc;
    endfunction

    logic [W-1:0] sq2;
    logic [W-1:0] prod;
    logic [W-1:0] xt  [W];
    logic [W-1:0] acc [W];

    assign sq2 = gf_mul(sq_reg, sq_reg);

    // res * sq^2: shifted multiplicands of sq^2 gated by the bits of res.
    assign xt[0]  = sq2;
    assign acc[0] = res_reg[0] ? sq2 : '0;
    generate
        for (genvar gi = 1; gi < W; gi++) begin : g_prod
            assign xt[gi]  = xtime(xt[gi-1]);
            assign acc[gi] = acc[gi-1] ^ (res_reg[gi] ? xt[gi] : '0);
        end
    endgenerate
    assign prod = acc[W-1];

    always_comb begin
        state_next = state_reg;
        sq_next    = sq_reg;
        res_next   = res_reg;
        tag_next   = tag_reg;
        zf_next    = zf_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (in_valid) begin
                    sq_next    = in_data;
                    res_next   = W'(1);
                    tag_next   = in_tag;
                    zf_next    = (in_data == '0);
                    cnt_next   = '0;
                    state_next = ST_CALC;
                end
            end
            ST_CALC: begin
                sq_next  = sq2;
                res_next = prod;
                if (cnt_reg == CNT_LAST)
                    state_next = ST_DONE;
                else
                    cnt_next = cnt_reg + 1'b1;
            end
            ST_DONE: begin
                if (out_ready)
                    state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sq_reg    <= '0;
            res_reg   <= '0;
            tag_reg   <= '0;
            zf_reg    <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sq_reg    <= sq_next;
            res_reg   <= res_next;
            tag_reg   <= tag_next;
            zf_reg    <= zf_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Handshake outputs decode the state directly so reset clears them without a clock.
    assign in_ready  = (state_reg == ST_IDLE);
    assign out_valid = (state_reg == ST_DONE);
    assign busy      = (state_reg != ST_IDLE);
    assign out_data  = res_reg;
    assign out_tag   = tag_reg;
    assign out_zero  = zf_reg;

endmodule

// File: tb/tb_gf_inv_iter.sv
// Directed bench for gf_inv_iter: W=8 (POLY 11B) and W=4 (POLY 13) instances checked
// against hand values and a brute-force inverse model.
module tb_gf_inv_iter;

    logic       clk;
    logic       rst;
    logic       iv8, ir8, ov8, or8, oz8, b8;
    logic [7:0] id8, od8;
    logic [3:0] it8, ot8;
    logic       iv4, ir4, ov4, or4, oz4, b4;
    logic [3:0] id4, od4;
    logic [3:0] it4, ot4;

    int total = 0;
    int bad   = 0;

    gf_inv_iter #(.W(8), .POLY(9'h11B), .TAG_W(4)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(iv8), .in_ready(ir8), .in_data(id8), .in_tag(it8),
        .out_valid(ov8), .out_ready(or8), .out_data(od8), .out_tag(ot8),
        .out_zero(oz8), .busy(b8)
    );

    gf_inv_iter #(.W(4), .POLY(5'h13), .TAG_W(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(iv4), .in_ready(ir4), .in_data(id4), .in_tag(it4),
        .out_valid(ov4), .out_ready(or4), .out_data(od4), .out_tag(ot4),
        .out_zero(oz4), .busy(b4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Horner-form multiply in GF(2^w)
    function automatic logic [7:0] mdl_mul(input logic [7:0] x, input logic [7:0] y,
                                           input int w, input logic [8:0] poly);
        logic [8:0] p;
        p = '0;
        for (int i = w - 1; i >= 0; i--) begin
            p = p << 1;
            if (p[w])
                p = p ^ poly;
            if (y[i])
                p = p ^ {1'b0, x};
        end
        return p[7:0];
    endfunction

    function automatic logic [7:0] mdl_inv(input logic [7:0] a, input int w, input logic [8:0] poly);
        logic [7:0] r;
        r = '0;
        for (int b = 1; b < (1 << w); b++)
            if (a != 0 && mdl_mul(a, 8'(b), w, poly) == 8'h01)
                r = 8'(b);
        return r;
    endfunction

    task automatic run8(input logic [7:0] a, input logic [3:0] t, output logic [7:0] got);
        int lat;
        int guard;
        guard = 0;
        while (!ir8 && guard < 40) begin tick(); guard++; end
        chk("w8_ready", {31'd0, ir8}, 32'd1);
        id8 = a; it8 = t; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        lat = 1;
        while (!ov8 && lat < 40) begin tick(); lat++; end
        chk("w8_latency", lat, 32'd8);
        got = od8;
        chk("w8_tag", {28'd0, ot8}, {28'd0, t});
        chk("w8_zero", {31'd0, oz8}, {31'd0, (a == 8'h00)});
        $display("txn w8 a=%h tag=%h -> data=%h zero=%b lat=%0d", a, t, od8, oz8, lat);
        or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("w8_drop", {31'd0, ov8}, 32'd0);
        chk("w8_idle", {31'd0, ir8}, 32'd1);
    endtask

    task automatic run4(input logic [3:0] a, input logic [3:0] t, output logic [3:0] got);
        int lat;
        int guard;
        guard = 0;
        while (!ir4 && guard < 40) begin tick(); guard++; end
        chk("w4_ready", {31'd0, ir4}, 32'd1);
        id4 = a; it4 = t; iv4 = 1'b1;
        tick();
        iv4 = 1'b0;
        lat = 1;
        while (!ov4 && lat < 40) begin tick(); lat++; end
        chk("w4_latency", lat, 32'd4);
        got = od4;
        chk("w4_tag", {28'd0, ot4}, {28'd0, t});
        chk("w4_zero", {31'd0, oz4}, {31'd0, (a == 4'h0)});
        $display("txn w4 a=%h tag=%h -> data=%h zero=%b lat=%0d", a, t, od4, oz4, lat);
        or4 = 1'b1;
        tick();
        or4 = 1'b0;
        chk("w4_drop", {31'd0, ov4}, 32'd0);
    endtask

    initial begin
        logic [7:0] g8;
        logic [3:0] g4;
        logic [7:0] ops [4];
        logic       acc_now;
        int         idx_in, idx_out, last_cyc;

        rst = 1'b1;
        iv8 = 0; or8 = 0; id8 = '0; it8 = '0;
        iv4 = 0; or4 = 0; id4 = '0; it4 = '0;
        #3;
        chk("rst_in_ready", {31'd0, ir8}, 32'd1);
        chk("rst_out_valid", {31'd0, ov8}, 32'd0);
        chk("rst_busy", {31'd0, b8}, 32'd0);
        chk("rst_out_data", {24'd0, od8}, 32'd0);
        chk("rst_out_tag", {28'd0, ot8}, 32'd0);
        chk("rst_out_zero", {31'd0, oz8}, 32'd0);
        chk("rst_w4_ready", {31'd0, ir4}, 32'd1);
        tick(); tick();
        #2 rst = 1'b0;
        tick();

        // Hand-computed W=8 vectors
        run8(8'h53, 4'h5, g8); chk("w8_53", {24'd0, g8}, 32'hCA);
        run8(8'h01, 4'h1, g8); chk("w8_01", {24'd0, g8}, 32'h01);
        run8(8'h02, 4'h2, g8); chk("w8_02", {24'd0, g8}, 32'h8D);
        run8(8'h00, 4'h3, g8); chk("w8_00", {24'd0, g8}, 32'h00);

        // Hand-computed W=4 vectors
        run4(4'h2, 4'h7, g4); chk("w4_2", {28'd0, g4}, 32'h9);
        run4(4'h1, 4'h8, g4); chk("w4_1", {28'd0, g4}, 32'h1);

        // Exhaustive sweeps against the brute-force model
        for (int a = 0; a < 256; a++) begin
            run8(8'(a), 4'(a), g8);
            chk("w8_sweep", {24'd0, g8}, {24'd0, mdl_inv(8'(a), 8, 9'h11B)});
            if (a != 0)
                chk("w8_prod_one", {24'd0, mdl_mul(8'(a), g8, 8, 9'h11B)}, 32'h01);
        end
        for (int a = 0; a < 16; a++) begin
            run4(4'(a), 4'(a), g4);
            chk("w4_sweep", {28'd0, g4}, {24'd0, mdl_inv(8'(a), 4, 9'h013)});
        end

        // Backpressure: hold DONE for 10 cycles with a competing input offered
        id8 = 8'h53; it8 = 4'hA; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("bp_enter_done", {31'd0, ov8}, 32'd1);
        id8 = 8'h02; it8 = 4'h6; iv8 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", {31'd0, ov8}, 32'd1);
            chk("bp_data", {24'd0, od8}, 32'hCA);
            chk("bp_tag", {28'd0, ot8}, 32'hA);
            chk("bp_in_ready", {31'd0, ir8}, 32'd0);
        end
        $display("txn w8 backpressure a=53 tag=a -> data=%h", od8);
        iv8 = 1'b0; or8 = 1'b1;
        tick();
        or8 = 1'b0;
        chk("bp_release_valid", {31'd0, ov8}, 32'd0);
        chk("bp_release_ready", {31'd0, ir8}, 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("bp_single_transfer", {30'd0, ov8, b8}, 32'd0);

        // Reset in the third CALC cycle
        id8 = 8'h02; it8 = 4'h4; iv8 = 1'b1;
        tick();
        iv8 = 1'b0;
        tick(); tick();
        chk("rc_busy_before", {31'd0, b8}, 32'd1);
        rst = 1'b1;
        #1;
        chk("rc_out_valid", {31'd0, ov8}, 32'd0);
        chk("rc_in_ready", {31'd0, ir8}, 32'd1);
        chk("rc_busy", {31'd0, b8}, 32'd0);
        #2 rst = 1'b0;
        $display("txn w8 reset mid-calc a=02 discarded");
        tick();
        run8(8'h53, 4'hB, g8); chk("rc_after_53", {24'd0, g8}, 32'hCA);

        // Back-to-back: in_valid held high, out_ready held high
        ops[0] = 8'h01; ops[1] = 8'h02; ops[2] = 8'h53; ops[3] = 8'h00;
        idx_in = 0; idx_out = 0; last_cyc = 0;
        or8 = 1'b1; iv8 = 1'b1; id8 = ops[0]; it8 = 4'd3;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc_now = ir8 && iv8;
            tick();
            if (acc_now) begin
                idx_in++;
                if (idx_in < 4) begin
                    id8 = ops[idx_in]; it8 = 4'(idx_in + 3);
                end else begin
                    iv8 = 1'b0;
                end
            end
            if (ov8 && idx_out < 4) begin
                chk("b2b_data", {24'd0, od8}, {24'd0, mdl_inv(ops[idx_out], 8, 9'h11B)});
                chk("b2b_tag", {28'd0, ot8}, 32'(idx_out + 3));
                if (idx_out > 0)
                    chk("b2b_interval", cyc - last_cyc, 32'd9);
                $display("txn w8 b2b tag=%h -> data=%h cycle=%0d", ot8, od8, cyc);
                last_cyc = cyc;
                idx_out++;
            end
        end
        or8 = 1'b0;
        chk("b2b_count", idx_out, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
